// File: rtl/audio_clk_nco_if.sv
// Control/clock-output bundle for audio_clk_nco: run/load/increment in,
// per-channel clocks, tick pulses and lock status out.
interface audio_clk_nco_if #(
    parameter int ACC_W    = 32,
    parameter int NUM_CLKS = 2
);
    logic                      enable;
    logic                      load;
    logic [NUM_CLKS*ACC_W-1:0] incr;
    logic [NUM_CLKS-1:0]       outclk;
    logic [NUM_CLKS-1:0]       tick;
    logic                      locked;

    modport master (
        output enable, load, incr,
        input  outclk, tick, locked
    );

    modport slave (
        input  enable, load, incr,
        output outclk, tick, locked
    );
endinterface

// File: rtl/audio_clk_nco.sv
// Multi-channel phase-accumulator NCO: each channel's accumulator MSB is a
// square-wave clock at f_refclk*incr/2^ACC_W; all channels share one lock FSM.
module audio_clk_nco #(
    parameter int          ACC_W       = 32,
    parameter int          NUM_CLKS    = 2,
    parameter int          LOCK_CYCLES = 16,
    parameter logic [47:0] RESET_INCR  = 48'd1055531162
) (
    input  logic            refclk,
    input  logic            rst,
    audio_clk_nco_if.slave  bus
);
    localparam int               CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] INCR_RST  = RESET_INCR[ACC_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_run;
    logic                w_cnt_clr;
    logic [ACC_W-1:0]    r_incr    [NUM_CLKS];
    logic [ACC_W-1:0]    r_acc     [NUM_CLKS];
    logic [ACC_W-1:0]    w_acc_nxt [NUM_CLKS];
    logic [NUM_CLKS-1:0] r_tick;
    logic                r_locked;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge refclk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Priority below reset: load, then enable low, then normal progression.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_cnt_clr   = 1'b1;
        if (bus.load) begin
            w_state_nxt = bus.enable ? ST_SETTLE : ST_IDLE;
        end else if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    w_run     = 1'b1;
                    w_cnt_clr = 1'b0;
                    if (r_cnt == LOCK_LAST) w_state_nxt = ST_LOCKED;
                end
                ST_LOCKED: w_run = 1'b1;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Anything other than running clears the accumulators, phase-aligning channels.
    always_comb begin
        for (int k = 0; k < NUM_CLKS; k++) begin
            w_acc_nxt[k] = w_run ? r_acc[k] + r_incr[k] : '0;
        end
    end

    // NOTE: these register arrays are small and must hold defined values
    // (RESET_INCR) after reset, so they are reset explicitly, unlike RAM.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLKS; k++) begin
                r_acc[k]  <= '0;
                r_incr[k] <= INCR_RST;
            end
            r_tick   <= '0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CLKS; k++) begin
                r_acc[k]  <= w_acc_nxt[k];
                r_tick[k] <= w_acc_nxt[k][ACC_W-1] & ~r_acc[k][ACC_W-1];
                if (bus.load) r_incr[k] <= bus.incr[k*ACC_W +: ACC_W];
            end
            r_cnt    <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            r_locked <= (w_state_nxt == ST_LOCKED);
        end
    end

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_outclk
        assign bus.outclk[g] = r_acc[g][ACC_W-1];
    end
    assign bus.tick   = r_tick;
    assign bus.locked = r_locked;

endmodule
